// File: rtl/cpu7_ifu_imem_bridge.sv
// Fetch-side bridge between the IFU fetch datapath and a single-outstanding SRAM-like
// instruction bus. It delivers one instruction per request, raises ADEF and drops cancelled fetches.
module cpu7_ifu_imem_bridge #(
  parameter logic [31:0] UNC_BASE  = 32'hA000_0000,
  parameter logic [31:0] UNC_MASK  = 32'hE000_0000,
  parameter logic [5:0]  ADEF_CODE = 6'h08
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inst_req,
  input  logic [31:0]  inst_addr,
  input  logic         inst_cancel,
  output logic         inst_addr_ok,
  output logic         inst_valid,
  output logic [127:0] inst_rdata,
  output logic [1:0]   inst_count,
  output logic         inst_ex,
  output logic [5:0]   inst_exccode,
  output logic         inst_uncache,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_addr_ok,
  input  logic         imem_data_ok,
  input  logic [31:0]  imem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_DRAIN,
    S_RESP,
    S_EXC
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        unc_q, unc_d;
  logic [31:0] last_q, last_d;

  logic        req_live;
  logic        misaligned;
  logic        bus_req;
  logic        addr_ok;
  logic        resp_valid;
  logic        resp_ex;
  logic        resp_unc;
  logic [31:0] resp_data;
  logic        valid_g;

  assign req_live   = inst_req & ~inst_cancel;
  assign misaligned = |inst_addr[1:0];

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    unc_d      = unc_q;
    bus_req    = 1'b0;
    addr_ok    = 1'b0;
    resp_valid = 1'b0;
    resp_ex    = 1'b0;
    resp_unc   = 1'b0;
    resp_data  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_live) begin
          if (misaligned) begin
            addr_ok = 1'b1;
            state_d = S_EXC;
          end else begin
            bus_req = 1'b1;
            if (imem_addr_ok) begin
              addr_ok = 1'b1;
              unc_d   = ((inst_addr & UNC_MASK) == UNC_BASE);
              state_d = S_WAIT_DATA;
            end
          end
        end
      end
      S_WAIT_DATA: begin
        // A cancel landing together with data_ok retires the bus beat with nothing to drain.
        if (imem_data_ok) begin
          if (inst_cancel) begin
            state_d = S_IDLE;
          end else begin
            data_d  = imem_rdata;
            state_d = S_RESP;
          end
        end else if (inst_cancel) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_data_ok) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        resp_valid = ~inst_cancel;
        resp_data  = data_q;
        resp_unc   = unc_q;
        state_d    = S_IDLE;
      end
      S_EXC: begin
        resp_valid = ~inst_cancel;
        resp_ex    = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted; rdata otherwise holds the last delivery.
  assign valid_g = resp_valid & ~reset;
  assign last_d  = valid_g ? resp_data : last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= 32'h0;
      unc_q   <= 1'b0;
      last_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      unc_q   <= unc_d;
      last_q  <= last_d;
    end
  end

  assign inst_addr_ok = addr_ok & ~reset;
  assign imem_req     = bus_req & ~reset;
  assign imem_addr    = imem_req ? {inst_addr[31:2], 2'b00} : 32'h0;
  assign inst_valid   = valid_g;
  assign inst_ex      = valid_g & resp_ex;
  assign inst_exccode = inst_ex ? ADEF_CODE : 6'h00;
  assign inst_uncache = valid_g & resp_unc;
  assign inst_count   = 2'b00;
  assign inst_rdata   = {96'h0, (reset ? 32'h0 : (valid_g ? resp_data : last_q))};

endmodule

// File: tb/tb_cpu7_ifu_imem_bridge.sv
// Bench for cpu7_ifu_imem_bridge: directed scenarios then random traffic, every cycle compared
// against a transaction-level model (outstanding bus beat, kill flag, pending response).
module tb_cpu7_ifu_imem_bridge;

  localparam logic [31:0] UNC_BASE  = 32'hA000_0000;
  localparam logic [31:0] UNC_MASK  = 32'hE000_0000;
  localparam logic [5:0]  ADEF_CODE = 6'h08;

  logic         clock = 1'b0;
  logic         reset;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_cancel;
  logic         inst_addr_ok;
  logic         inst_valid;
  logic [127:0] inst_rdata;
  logic [1:0]   inst_count;
  logic         inst_ex;
  logic [5:0]   inst_exccode;
  logic         inst_uncache;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_addr_ok;
  logic         imem_data_ok;
  logic [31:0]  imem_rdata;

  cpu7_ifu_imem_bridge #(
    .UNC_BASE (UNC_BASE),
    .UNC_MASK (UNC_MASK),
    .ADEF_CODE(ADEF_CODE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_addr_ok(inst_addr_ok),
    .inst_valid  (inst_valid),
    .inst_rdata  (inst_rdata),
    .inst_count  (inst_count),
    .inst_ex     (inst_ex),
    .inst_exccode(inst_exccode),
    .inst_uncache(inst_uncache),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_addr_ok(imem_addr_ok),
    .imem_data_ok(imem_data_ok),
    .imem_rdata  (imem_rdata)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int n_cycle = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle=%0d: got %h expected %h", tag, n_cycle, obs, exp);
  endtask

  // Bus responder: accepts after b_aok_wait cycles of held request, answers after b_cnt cycles.
  bit          b_busy     = 0;
  int          b_cnt      = 0;
  int          b_aok_wait = 0;
  logic [31:0] b_data     = 32'h0;
  int          aok_max    = 0;
  int          dly_min    = 0;
  int          dly_max    = 0;
  bit          use_forced = 0;
  logic [31:0] forced_data = 32'h0;

  // Reference model: one outstanding bus beat (possibly killed) and at most one queued response.
  bit          m_busy   = 0;
  bit          m_killed = 0;
  bit          m_resp   = 0;
  bit          m_rex    = 0;
  bit          m_runc   = 0;
  logic [31:0] m_rdata  = 32'h0;
  logic [31:0] m_last   = 32'h0;

  task automatic step(input bit rst, input bit req, input bit cancel, input logic [31:0] addr);
    bit aok, dok, want, mis, e_valid, e_ex, e_unc, e_ireq, e_aok, was_busy, saw_req;
    logic [31:0] e_rdata;
    reset       = rst;
    inst_req    = req;
    inst_cancel = cancel;
    inst_addr   = addr;
    aok = !b_busy && (b_aok_wait == 0);
    dok = b_busy && (b_cnt == 0);
    imem_addr_ok = aok;
    imem_data_ok = dok;
    imem_rdata   = dok ? b_data : $urandom;
    @(negedge clock);
    n_cycle++;

    mis  = (addr[1:0] != 2'b00);
    want = !rst && !m_busy && !m_resp && req && !cancel;
    e_valid = !rst && m_resp && !cancel;
    e_ex    = e_valid && m_rex;
    e_unc   = e_valid && m_runc;
    e_rdata = rst ? 32'h0 : (e_valid ? (m_rex ? 32'h0 : m_rdata) : m_last);
    e_ireq  = want && !mis;
    e_aok   = want && (mis || aok);

    chk("addr_ok",  inst_addr_ok, e_aok);
    chk("imem_req", imem_req, e_ireq);
    chk("imem_addr", imem_addr, e_ireq ? addr : 32'h0);
    chk("valid",    inst_valid, e_valid);
    chk("ex",       inst_ex, e_ex);
    chk("exccode",  inst_exccode, e_ex ? ADEF_CODE : 6'h00);
    chk("uncache",  inst_uncache, e_unc);
    chk("rdata_lo", inst_rdata[31:0], e_rdata);
    chk("rdata_hi", |inst_rdata[127:32], 1'b0);
    chk("count",    inst_count, 2'b00);

    if (rst) begin
      m_busy = 0; m_killed = 0; m_resp = 0; m_last = 32'h0;
    end else begin
      if (e_valid) m_last = e_rdata;
      was_busy = m_busy;
      m_resp = 0;
      if (want && mis) begin
        m_resp = 1; m_rex = 1; m_runc = 0;
      end else if (want && aok) begin
        m_busy = 1; m_killed = 0;
        m_runc = ((addr & UNC_MASK) == UNC_BASE);
      end
      if (was_busy) begin
        if (dok) begin
          m_busy = 0;
          if (!m_killed && !cancel) begin
            m_resp = 1; m_rex = 0; m_rdata = b_data;
          end
        end else if (cancel) begin
          m_killed = 1;
        end
      end
    end

    saw_req = imem_req;
    if (dok) b_busy = 0;
    else if (b_busy) b_cnt--;
    if (saw_req) begin
      if (aok) begin
        b_busy     = 1;
        b_cnt      = $urandom_range(dly_max, dly_min);
        b_data     = use_forced ? forced_data : $urandom;
        b_aok_wait = $urandom_range(aok_max, 0);
      end else if (b_aok_wait > 0) begin
        b_aok_wait--;
      end
    end
    @(posedge clock);
    #1;
  endtask

  logic [31:0] r_addr;
  bit          r_req, r_cancel, r_rst;
  int          sel;

  initial begin
    reset = 1'b1; inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = 32'h0;
    imem_addr_ok = 1'b0; imem_data_ok = 1'b0; imem_rdata = 32'h0;
    @(posedge clock); #1;
    step(1, 0, 0, 32'h0);
    step(1, 1, 0, 32'h1C00_0000);

    // Zero-wait fetch of a known word.
    use_forced = 1; forced_data = 32'h0280_0421;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h1C00_0000);
    step(0, 0, 0, 32'h0);
    use_forced = 0;

    // Uncached fetch with the request held three cycles before acceptance.
    b_aok_wait = 2;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 32'hA000_0010);
    step(0, 0, 0, 32'h0);

    // Misaligned fetch raises ADEF without a bus request.
    for (int i = 0; i < 2; i++) step(0, 1, 0, 32'h1C00_0002);
    step(0, 0, 0, 32'h0);

    // Cancel while waiting; data arrives later and must be drained.
    dly_min = 2; dly_max = 2;
    step(0, 1, 0, 32'h1C00_0000);
    step(0, 1, 1, 32'h1C00_0000);
    dly_min = 0; dly_max = 0;
    for (int i = 0; i < 7; i++) step(0, 1, 0, 32'h1C00_0100);
    step(0, 0, 0, 32'h0);

    // Cancel coincident with data_ok.
    dly_min = 1; dly_max = 1;
    step(0, 1, 0, 32'h1C00_0200);
    step(0, 1, 0, 32'h1C00_0200);
    step(0, 1, 1, 32'h1C00_0200);
    step(0, 0, 0, 32'h0);

    // Cancel in the response cycle, then in the exception cycle.
    dly_min = 0; dly_max = 0;
    step(0, 1, 0, 32'h1C00_0300);
    step(0, 1, 0, 32'h1C00_0300);
    step(0, 1, 1, 32'h1C00_0300);
    step(0, 1, 0, 32'h1C00_0301);
    step(0, 1, 1, 32'h1C00_0301);
    step(0, 0, 0, 32'h0);

    // Reset while waiting; the stale beat lands after reset releases.
    dly_min = 3; dly_max = 3;
    step(0, 1, 0, 32'h1C00_0400);
    step(0, 1, 0, 32'h1C00_0400);
    step(1, 1, 0, 32'h1C00_0400);
    dly_min = 0; dly_max = 0;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 32'h1C00_0500);
    step(0, 0, 0, 32'h0);

    // Random traffic.
    aok_max = 3; dly_min = 0; dly_max = 4;
    r_addr = 32'h1C00_0000;
    for (int i = 0; i < 3000; i++) begin
      r_rst    = ($urandom_range(299, 0) == 0);
      r_req    = ($urandom_range(9, 0) < 8);
      r_cancel = ($urandom_range(9, 0) == 0);
      if ($urandom_range(9, 0) < 3) begin
        sel = $urandom_range(3, 0);
        case (sel)
          0: r_addr = 32'h1C00_0000;
          1: r_addr = 32'hA000_0000;
          2: r_addr = 32'hBFC0_0000;
          default: r_addr = $urandom;
        endcase
        r_addr = r_addr + {20'h0, $urandom_range(4095, 0)} * 4;
        if ($urandom_range(3, 0) == 0) r_addr[1:0] = 2'($urandom_range(3, 1));
      end
      step(r_rst, r_req, r_cancel, r_addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_imem_bridge.md
Name: cpu7_ifu_imem_bridge

Overview:
Fetch-side bus bridge directly upstream of the IFU fetch datapath.
- Accepts the per-cycle fetch request (inst_req/inst_addr/inst_cancel) and returns one 32-bit instruction per request (inst_valid/inst_rdata/inst_ex/inst_exccode/inst_uncache).
- Drives a single-outstanding SRAM-like instruction bus (imem_*).
- Drops responses belonging to cancelled requests (branch, exception, ertn).
- Raises ADEF for misaligned fetch addresses without touching the bus.

Parameters:
UNC_BASE, 32'hA000_0000, uncached-region base; fetch is uncached when (addr & UNC_MASK) == UNC_BASE
UNC_MASK, 32'hE000_0000, uncached-region compare mask
ADEF_CODE, 6'h08, exccode reported for misaligned fetch

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
inst_req  in  1  fetch request from fetch datapath
inst_addr  in  32  fetch address (pc_bf)
inst_cancel  in  1  kill any in-flight fetch; pulse
inst_addr_ok  out  1  request accepted this cycle
inst_valid  out  1  response pulse; one instruction delivered
inst_rdata  out  128  {96'b0, instruction}
inst_count  out  2  constant 2'b00 (one instruction, slot 0)
inst_ex  out  1  fetch exception with inst_valid
inst_exccode  out  6  exccode with inst_ex, else 0
inst_uncache  out  1  delivered fetch was in uncached region
imem_req  out  1  bus request
imem_addr  out  32  bus address, word aligned
imem_addr_ok  in  1  bus accepted request
imem_data_ok  in  1  bus read data valid
imem_rdata  in  32  bus read data

Behaviour:
- Reset: state IDLE; all outputs 0 except inst_count = 0. Reset mid-transaction abandons it. A bus data_ok arriving after reset deasserts is ignored while in IDLE.
- States: IDLE, WAIT_DATA, DRAIN, RESP, EXC.
- IDLE, inst_req=1, inst_cancel=0:
  - addr[1:0] != 0: inst_addr_ok=1, no bus request, latch exccode, go EXC.
  - Aligned: imem_req=1, imem_addr=inst_addr (combinational). On imem_addr_ok=1: inst_addr_ok=1, latch uncache flag, go WAIT_DATA. Otherwise stay in IDLE.
- IDLE with inst_cancel=1: imem_req=0, inst_addr_ok=0, stay in IDLE. The new target is accepted the following cycle.
- WAIT_DATA: imem_req=0, new requests ignored.
  - imem_data_ok=1 and inst_cancel=0: latch imem_rdata, go RESP.
  - inst_cancel=1 with data_ok=0: go DRAIN.
  - inst_cancel=1 with data_ok=1 in the same cycle: discard data, go IDLE.
- DRAIN: imem_req=0, inst_valid never asserted. On imem_data_ok, discard data and go IDLE. inst_cancel in DRAIN has no further effect.
- RESP, one cycle:
  - inst_valid = ~inst_cancel; inst_rdata[31:0] = latched data; inst_uncache = latched flag; inst_ex=0.
  - Always return to IDLE; no request is accepted in RESP.
- EXC, one cycle: inst_valid = ~inst_cancel, inst_ex=1, inst_exccode=ADEF_CODE, inst_rdata=0, inst_uncache=0. Go IDLE.
- inst_ex and inst_exccode are 0 whenever inst_valid=0. inst_rdata holds its last value when inst_valid=0.
- Latency: accept (cycle N) -> data_ok (N+k, k≥1) -> inst_valid at N+k+1. With zero-wait bus (k=1) throughput is one instruction per 3 cycles.
- At most one bus transaction outstanding. The bridge never issues imem_req outside IDLE.
- imem_req may drop before imem_addr_ok when inst_req drops or cancel arrives; the bus must tolerate request withdrawal.
- Fetch datapath holds inst_addr while inst_valid=0, so re-presentation of the same address during WAIT_DATA/DRAIN is ignored and harmless.

Test Plan:
- Reset, inst_req=1, inst_addr=0x1C00_0000, bus accepts immediately, data_ok next cycle with 0x0280_0421 -> imem_req/imem_addr_ok at cycle 0, inst_valid=1 at cycle 2 with inst_rdata[31:0]=0x0280_0421, inst_uncache=0, inst_ex=0.
- inst_addr=0xA000_0010 with 3-cycle addr_ok delay -> imem_req held 3 cycles, inst_addr_ok coincides with imem_addr_ok, inst_uncache=1 on the response.
- inst_addr=0x1C00_0002 -> no imem_req ever; inst_addr_ok=1, next cycle inst_valid=1, inst_ex=1, inst_exccode=6'h08.
- Accept 0x1C00_0000, cancel in WAIT_DATA, data_ok 2 cycles later, new inst_addr=0x1C00_0100 -> old data never reaches inst_valid; state DRAIN until data_ok; next bus request addr=0x1C00_0100 and its data delivered.
- Cancel coincident with data_ok, and cancel during RESP/EXC -> inst_valid stays 0 in both cases; bridge back in IDLE next cycle.
- Reset asserted in WAIT_DATA, stray data_ok one cycle after reset release -> no inst_valid; first post-reset request issues normally.
